// File: rtl/operand_latch_bank.sv
// Operand capture stage between the register-file read ports and the ALU: CHANNELS
// independent operand latches, each with a valid flag, consume handshake, writeback
// forwarding, flush and a sticky overrun flag.
// Latency: 1 clock from an accepted load to operand_out/operand_valid.
// Backpressure: ready[ch] = !operand_valid[ch] | consume[ch]. A load into a full channel
//   is dropped (the old operand is kept) and sets overrun[ch].
// Ports:
//   clock, reset             rising-edge clock; asynchronous active-high reset
//   run                      global enable (flush and clr_overrun act regardless)
//   load, src_addr, operand_in   per-channel capture request, source register, read data
//   wb_valid, wb_addr, wb_data   writeback in flight, forwarded into same-cycle captures
//   consume, flush, clr_overrun  ALU take, discard all pending, clear sticky overrun
//   operand_out, operand_valid, all_valid, ready, overrun   registered state / handshake
module operand_latch_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       run,
  input  logic [CHANNELS-1:0]        load,
  input  logic [CHANNELS*ADDR_W-1:0] src_addr,
  input  logic [CHANNELS*WIDTH-1:0]  operand_in,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [WIDTH-1:0]           wb_data,
  input  logic [CHANNELS-1:0]        consume,
  input  logic                       flush,
  input  logic                       clr_overrun,
  output logic [CHANNELS*WIDTH-1:0]  operand_out,
  output logic [CHANNELS-1:0]        operand_valid,
  output logic                       all_valid,
  output logic [CHANNELS-1:0]        ready,
  output logic [CHANNELS-1:0]        overrun
);

  logic [CHANNELS*WIDTH-1:0] operand_q, operand_d;
  logic [CHANNELS-1:0]       valid_q, valid_d;
  logic [CHANNELS-1:0]       overrun_q, overrun_d;

  always_comb begin
    operand_d = operand_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ready     = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      logic             capture;
      logic             drop;
      logic [WIDTH-1:0] cap_val;
      // A consume in the same cycle frees the slot, allowing back-to-back loads.
      ready[ch] = !valid_q[ch] || consume[ch];
      capture   = run && load[ch] && ready[ch] && !flush;
      drop      = run && load[ch] && !ready[ch] && !flush;
      // Writeback forwarding: the register file read returns stale data when the
      // same register is being written this cycle.
      if (wb_valid && (wb_addr == src_addr[ch*ADDR_W +: ADDR_W]))
        cap_val = wb_data;
      else
        cap_val = operand_in[ch*WIDTH +: WIDTH];

      if (flush) begin
        valid_d[ch] = 1'b0;
      end else if (capture) begin
        valid_d[ch]                    = 1'b1;
        operand_d[ch*WIDTH +: WIDTH]   = cap_val;
      end else if (run && consume[ch] && valid_q[ch]) begin
        valid_d[ch] = 1'b0;
      end

      // A new overrun event beats a simultaneous clear.
      if (drop)
        overrun_d[ch] = 1'b1;
      else if (clr_overrun)
        overrun_d[ch] = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      operand_q <= '0;
      valid_q   <= '0;
      overrun_q <= '0;
    end else begin
      operand_q <= operand_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign operand_out   = operand_q;
  assign operand_valid = valid_q;
  assign overrun       = overrun_q;
  assign all_valid     = &valid_q;

endmodule

// File: tb/tb_operand_latch_bank.sv
// Directed bench for operand_latch_bank: a default build (2 x 8-bit) and a
// 4 x 16-bit build sharing one clock and reset.
module tb_operand_latch_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  // default build
  logic        run, wb_valid, flush, clr_overrun;
  logic [1:0]  load, consume, wb_addr;
  logic [3:0]  src_addr;
  logic [15:0] operand_in;
  logic [7:0]  wb_data;
  logic [15:0] operand_out;
  logic [1:0]  operand_valid, ready, overrun;
  logic        all_valid;

  // wide build
  logic        run_b, wb_valid_b, flush_b, clr_b;
  logic [3:0]  load_b, consume_b;
  logic [1:0]  wb_addr_b;
  logic [7:0]  src_addr_b;
  logic [63:0] operand_in_b;
  logic [15:0] wb_data_b;
  logic [63:0] operand_out_b;
  logic [3:0]  valid_b, ready_b, overrun_b;
  logic        all_valid_b;

  int checks = 0;
  int errors = 0;

  operand_latch_bank dut (
    .clock(clock), .reset(reset), .run(run), .load(load), .src_addr(src_addr),
    .operand_in(operand_in), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .consume(consume), .flush(flush), .clr_overrun(clr_overrun),
    .operand_out(operand_out), .operand_valid(operand_valid), .all_valid(all_valid),
    .ready(ready), .overrun(overrun)
  );

  operand_latch_bank #(.WIDTH(16), .CHANNELS(4), .ADDR_W(2)) dut_b (
    .clock(clock), .reset(reset), .run(run_b), .load(load_b), .src_addr(src_addr_b),
    .operand_in(operand_in_b), .wb_valid(wb_valid_b), .wb_addr(wb_addr_b), .wb_data(wb_data_b),
    .consume(consume_b), .flush(flush_b), .clr_overrun(clr_b),
    .operand_out(operand_out_b), .operand_valid(valid_b), .all_valid(all_valid_b),
    .ready(ready_b), .overrun(overrun_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock; leave the bench 1 time unit after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    run = 0; load = 0; consume = 0; src_addr = 0; operand_in = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; flush = 0; clr_overrun = 0;
    run_b = 0; load_b = 0; consume_b = 0; src_addr_b = 0; operand_in_b = 0;
    wb_valid_b = 0; wb_addr_b = 0; wb_data_b = 0; flush_b = 0; clr_b = 0;

    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    chk("rst_out",     operand_out,   16'h0000);
    chk("rst_valid",   operand_valid, 2'b00);
    chk("rst_allv",    all_valid,     1'b0);
    chk("rst_ready",   ready,         2'b11);
    chk("rst_overrun", overrun,       2'b00);

    // 1: capture on ch1
    run = 1; load = 2'b10; src_addr = 4'b0100; operand_in = 16'h5A00;
    step();
    chk("t1_out",   operand_out,   16'h5A00);
    chk("t1_valid", operand_valid, 2'b10);
    chk("t1_allv",  all_valid,     1'b0);
    chk("t1_ready", ready,         2'b01);

    // 2: forwarding hit, then miss (back-to-back on ch0)
    load = 2'b01; src_addr = 4'b0111; operand_in = 16'h0011;
    wb_valid = 1; wb_addr = 2'd3; wb_data = 8'hC3;
    step();
    chk("t2_fwd_hit", operand_out,   16'h5AC3);
    chk("t2_valid",   operand_valid, 2'b11);
    chk("t2_allv",    all_valid,     1'b1);
    consume = 2'b01; wb_addr = 2'd2;
    step();
    chk("t2_fwd_miss", operand_out,   16'h5A11);
    chk("t2_valid2",   operand_valid, 2'b11);
    load = 2'b00; consume = 2'b11; wb_valid = 0;
    step();
    chk("t2_drain_valid", operand_valid, 2'b00);
    chk("t2_drain_keep",  operand_out,   16'h5A11);
    consume = 2'b11;   // consume on empty channels: ignored
    step();
    chk("t2_cons_empty", operand_valid, 2'b00);
    chk("t2_cons_ovr",   overrun,       2'b00);
    consume = 2'b00;

    // 3: overrun on ch1
    load = 2'b10; operand_in = 16'h2200;
    step();
    chk("t3_valid", operand_valid, 2'b10);
    operand_in = 16'h3300;
    step();
    chk("t3_keep_old", operand_out,   16'h2211);
    chk("t3_overrun",  overrun,       2'b10);
    chk("t3_valid2",   operand_valid, 2'b10);
    load = 2'b00; clr_overrun = 1;
    step();
    chk("t3_clr", overrun, 2'b00);
    load = 2'b10;     // new overrun together with clear: set wins
    step();
    chk("t3_set_wins", overrun, 2'b10);
    load = 2'b00;
    step();
    chk("t3_clr2", overrun, 2'b00);
    clr_overrun = 0;

    // 4: back-to-back on ch0
    load = 2'b01; operand_in = 16'h0001;
    step();
    chk("t4_first", operand_out, 16'h2201);
    consume = 2'b01; operand_in = 16'h0002;
    step();
    chk("t4_out",     operand_out,   16'h2202);
    chk("t4_valid",   operand_valid, 2'b11);
    chk("t4_overrun", overrun,       2'b00);

    // 5: flush with run=0, then run=0 holds everything
    run = 0; flush = 1; load = 2'b11; consume = 2'b00; operand_in = 16'hAABB;
    step();
    chk("t5_flush_valid", operand_valid, 2'b00);
    chk("t5_flush_keep",  operand_out,   16'h2202);
    flush = 0; run = 1; load = 2'b11; operand_in = 16'h4455;
    step();
    chk("t5_reload", operand_out, 16'h4455);
    run = 0; load = 2'b11; consume = 2'b11; operand_in = 16'h6677;
    step();
    chk("t5_hold_out",   operand_out,   16'h4455);
    chk("t5_hold_valid", operand_valid, 2'b11);
    chk("t5_hold_ovr",   overrun,       2'b00);

    // multi-channel forwarding of one writeback
    run = 1; src_addr = 4'b0101; wb_valid = 1; wb_addr = 2'd1; wb_data = 8'h5C;
    step();
    chk("t5_fwd_both", operand_out, 16'h5C5C);
    wb_valid = 0;

    // 6: async reset mid-cycle with both valid and overrun[0]=1
    load = 2'b01; consume = 2'b00;
    step();
    chk("t6_pre_ovr", overrun, 2'b01);
    load = 2'b00; run = 0;
    @(negedge clock);
    #1 reset = 1;
    #1;
    chk("t6_out",   operand_out,   16'h0000);
    chk("t6_valid", operand_valid, 2'b00);
    chk("t6_ovr",   overrun,       2'b00);
    chk("t6_ready", ready,         2'b11);
    step();
    reset = 0;

    // wide build: tests 1 and 3 per channel
    run_b = 1;
    for (int ch = 0; ch < 4; ch++) begin
      logic [15:0] v1, v2;
      logic [3:0]  bit_ch;
      v1 = 16'hA500 + 16'(ch);
      v2 = 16'h3C00 + 16'(ch);
      bit_ch = 4'(1 << ch);
      load_b = bit_ch; operand_in_b = '0; operand_in_b[ch*16 +: 16] = v1;
      step();
      chk("w_cap",   64'(operand_out_b[ch*16 +: 16]), 64'(v1));
      chk("w_valid", valid_b, bit_ch);
      operand_in_b[ch*16 +: 16] = v2;
      step();
      chk("w_keep",    64'(operand_out_b[ch*16 +: 16]), 64'(v1));
      chk("w_overrun", overrun_b, bit_ch);
      load_b = 0; consume_b = bit_ch; clr_b = 1;
      step();
      chk("w_clr",   overrun_b, 4'b0000);
      chk("w_empty", valid_b,   4'b0000);
      consume_b = 0; clr_b = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
